// File: rtl/uart_pkg.sv
// uart_pkg: shared UART parity encoding, Rx state encoding and default geometry.
package uart_pkg;
  localparam logic EVEN = 1'b0;
  localparam logic ODD = 1'b1;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_OVERSAMPLE = 16;
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;
endpackage

// File: rtl/rx_parity_checker.sv
// rx_parity_checker: flags a received parity bit that disagrees with the data word.
module rx_parity_checker
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  parity_sel_i,
  input  logic                  parity_bit_i,
  output logic                  parity_err_o
);
  always_comb parity_err_o = parity_bit_i != ((parity_sel_i == EVEN) ? ^data_i : ~^data_i);
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: oversampled UART receiver producing a word plus parity/framing flags per frame.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                  baud_clk,
  input  logic                  rst,
  input  logic                  rx_serial,
  input  logic                  rx_en,
  input  logic                  parity_en,
  input  logic                  parity_sel,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  rx_state_e state_q, state_d;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
  logic perr_q, perr_d, dv_q, dv_d, pe_q, pe_d, fe_q, fe_d;
  logic rx_s, mid, last, par_err;
  assign rx_s = sync_q[1];
  assign mid = cnt_q == CW'(OVERSAMPLE / 2 - 1);
  assign last = cnt_q == CW'(OVERSAMPLE - 1);
  rx_parity_checker #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data_i(shift_q),
    .parity_sel_i(parity_sel),
    .parity_bit_i(rx_s),
    .parity_err_o(par_err)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    perr_d = perr_q;
    data_d = data_q;
    dv_d = 1'b0;
    pe_d = pe_q;
    fe_d = fe_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_en && !rx_s) begin
          state_d = RX_START;
          perr_d = 1'b0;
        end
      end
      RX_START: if (mid) begin
        cnt_d = '0;
        bit_d = '0;
        state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (last) begin
        cnt_d = '0;
        shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(DATA_WIDTH - 1)) state_d = parity_en ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (last) begin
        cnt_d = '0;
        perr_d = par_err;
        state_d = RX_STOP;
      end
      RX_STOP: if (last) begin
        // perr_q is only ever set in PARITY, so a no-parity frame reports 0
        cnt_d = '0;
        data_d = shift_q;
        pe_d = perr_q;
        fe_d = !rx_s;
        dv_d = 1'b1;
        state_d = rx_s ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = RX_IDLE;
      end
      default: begin
        cnt_d = '0;
        state_d = RX_IDLE;
      end
    endcase
  end
  always_ff @(posedge baud_clk) begin
    if (!rst) begin
      state_q <= RX_IDLE;
      sync_q <= 2'b11;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      perr_q <= 1'b0;
      data_q <= '0;
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[0], rx_serial};
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      perr_q <= perr_d;
      data_q <= data_d;
      dv_q <= dv_d;
      pe_q <= pe_d;
      fe_q <= fe_d;
    end
  end
  assign data_out = data_q;
  assign data_valid = dv_q;
  assign parity_error = pe_q;
  assign framing_error = fe_q;
  assign busy = state_q != RX_IDLE;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: frame-level scoreboard bench for uart_rx_deframer with directed and random frames.
module tb_uart_rx_deframer;
  localparam int DW = 8;
  localparam int OS = 16;
  typedef struct {
    logic [DW-1:0] d;
    logic pe;
    logic fe;
    int t;
    int n;
  } exp_t;
  logic clk = 1'b0;
  logic rst, rx_serial, rx_en, parity_en, parity_sel;
  logic [DW-1:0] data_out;
  logic data_valid, parity_error, framing_error, busy;
  int checks = 0, errors = 0, cyc = 0, dv_count = 0;
  exp_t q[$];
  logic [DW-1:0] m_data = '0;
  logic m_pe = 1'b0, m_fe = 1'b0;
  uart_rx_deframer #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .baud_clk(clk),
    .rst(rst),
    .rx_serial(rx_serial),
    .rx_en(rx_en),
    .parity_en(parity_en),
    .parity_sel(parity_sel),
    .data_out(data_out),
    .data_valid(data_valid),
    .parity_error(parity_error),
    .framing_error(framing_error),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // Frame-level model: every pulse must match the oldest outstanding frame; outputs hold in between.
  task automatic monitor();
    exp_t e;
    int base;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        m_data = '0;
        m_pe = 1'b0;
        m_fe = 1'b0;
        q.delete();
      end
      @(negedge clk);
      if (data_valid === 1'b1) begin
        dv_count++;
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          e = q.pop_front();
          base = OS / 2 + e.n * OS;
          chk("latency_in_window", 32'((cyc - e.t) >= base + 2 && (cyc - e.t) <= base + 4), 1);
          m_data = e.d;
          m_pe = e.pe;
          m_fe = e.fe;
        end
      end
      chk("data_out", 32'(data_out), 32'(m_data));
      chk("parity_error", 32'(parity_error), 32'(m_pe));
      chk("framing_error", 32'(framing_error), 32'(m_fe));
    end
  endtask
  task automatic send(input logic [DW-1:0] d, input logic pbit, input logic stop, input bit exp_on, input bit drop);
    exp_t e;
    if (exp_on) begin
      e.d = d;
      e.pe = parity_en && ((($countones(d) + int'(pbit)) % 2) != int'(parity_sel));
      e.fe = !stop;
      e.t = cyc;
      e.n = DW + int'(parity_en) + 1;
      q.push_back(e);
    end
    rx_serial = 1'b0;
    tick(OS);
    if (drop) rx_en = 1'b0;
    for (int i = 0; i < DW; i++) begin
      rx_serial = d[i];
      tick(OS);
    end
    if (parity_en) begin
      rx_serial = pbit;
      tick(OS);
    end
    rx_serial = stop;
    tick(OS);
  endtask
  initial begin
    int n0;
    logic saw;
    logic [DW-1:0] rd;
    logic rstop;
    rst = 1'b0;
    rx_serial = 1'b1;
    rx_en = 1'b0;
    parity_en = 1'b0;
    parity_sel = 1'b0;
    fork
      monitor();
    join_none
    tick(4);
    chk("reset_data_out", 32'(data_out), 0);
    chk("reset_data_valid", 32'(data_valid), 0);
    chk("reset_flags", 32'({parity_error, framing_error}), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 1'b1;
    rx_en = 1'b1;
    tick(4);
    send(8'h5A, 1'b0, 1'b1, 1, 0);
    tick(OS);
    chk("8n1_5a_data", 32'(data_out), 32'h5A);
    chk("8n1_5a_flags", 32'({parity_error, framing_error}), 0);
    chk("8n1_5a_busy", 32'(busy), 0);
    chk("8n1_5a_pulses", 32'(dv_count), 1);
    parity_en = 1'b1;
    parity_sel = 1'b0;
    send(8'hA5, 1'b0, 1'b1, 1, 0);
    chk("8e1_a5_p0_perr", 32'(parity_error), 0);
    send(8'hA5, 1'b1, 1'b1, 1, 0);
    chk("8e1_a5_p1_perr", 32'(parity_error), 1);
    chk("8e1_a5_data", 32'(data_out), 32'hA5);
    parity_sel = 1'b1;
    send(8'h01, 1'b0, 1'b1, 1, 0);
    chk("8o1_01_p0_perr", 32'(parity_error), 0);
    send(8'h01, 1'b1, 1'b1, 1, 0);
    chk("8o1_01_p1_perr", 32'(parity_error), 1);
    parity_en = 1'b0;
    parity_sel = 1'b0;
    n0 = dv_count;
    send(8'h3C, 1'b0, 1'b0, 1, 0);
    tick(40 * OS);
    chk("break_framing_error", 32'(framing_error), 1);
    chk("break_data", 32'(data_out), 32'h3C);
    chk("break_busy_held", 32'(busy), 1);
    chk("break_single_pulse", 32'(dv_count - n0), 1);
    rx_serial = 1'b1;
    tick(OS);
    chk("break_released_busy", 32'(busy), 0);
    send(8'h77, 1'b0, 1'b1, 1, 0);
    tick(OS);
    chk("after_break_77", 32'(data_out), 32'h77);
    chk("after_break_flags", 32'({parity_error, framing_error}), 0);
    n0 = dv_count;
    saw = 1'b0;
    rx_serial = 1'b0;
    for (int i = 0; i < 2 * OS; i++) begin
      if (i == OS / 4) rx_serial = 1'b1;
      tick(1);
      saw = saw | busy;
    end
    chk("glitch_busy_pulsed", 32'(saw), 1);
    chk("glitch_busy_back", 32'(busy), 0);
    chk("glitch_no_valid", 32'(dv_count - n0), 0);
    n0 = dv_count;
    rx_serial = 1'b0;
    tick(OS);
    rx_serial = 1'b1;
    tick(3 * OS);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(7 * OS);
    chk("midframe_rst_data", 32'(data_out), 0);
    chk("midframe_rst_flags", 32'({parity_error, framing_error}), 0);
    chk("midframe_rst_busy", 32'(busy), 0);
    chk("midframe_rst_no_valid", 32'(dv_count - n0), 0);
    n0 = dv_count;
    send(8'h11, 1'b0, 1'b1, 1, 0);
    send(8'h22, 1'b0, 1'b1, 1, 0);
    tick(OS);
    chk("b2b_pulses", 32'(dv_count - n0), 2);
    chk("b2b_last_data", 32'(data_out), 32'h22);
    n0 = dv_count;
    rx_en = 1'b0;
    send(8'h5A, 1'b0, 1'b1, 0, 0);
    tick(OS);
    chk("rx_en_off_no_valid", 32'(dv_count - n0), 0);
    chk("rx_en_off_busy", 32'(busy), 0);
    rx_en = 1'b1;
    send(8'hC3, 1'b0, 1'b1, 1, 1);
    tick(OS);
    chk("rx_en_drop_completes", 32'(dv_count - n0), 1);
    chk("rx_en_drop_data", 32'(data_out), 32'hC3);
    rx_en = 1'b1;
    tick(OS);
    for (int k = 0; k < 40; k++) begin
      rd = DW'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      parity_en = 1'($urandom);
      parity_sel = 1'($urandom);
      send(rd, 1'($urandom), rstop, 1, 0);
      if (!rstop) begin
        rx_serial = 1'b1;
        tick(OS);
      end
      tick($urandom_range(0, 2 * OS));
    end
    tick(2 * OS);
    chk("all_frames_delivered", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
